// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I definitions for the nano core: widths, load funct3 codes and
// the writeback-stage state encoding.
package rv32i_defs_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Extracts and extends the byte/half/word a load asked for from an aligned
// memory word; flags misaligned addresses and non-load funct3 codes.
module load_align
  import rv32i_defs_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata_i[8*addr_lo_i +: 8];
  assign halfSel = rdata_i[16*addr_lo_i[1] +: 16];

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{24{byteSel[7]}}, byteSel};
      F3_LBU: data_o = {24'b0, byteSel};
      F3_LH: begin
        data_o = {{16{halfSel[15]}}, halfSel};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {16'b0, halfSel};
        err_o  = addr_lo_i[0];
      end
      F3_LW: begin
        data_o = rdata_i;
        err_o  = (addr_lo_i != 2'b00);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: retires ALU results in one cycle, waits for and formats
// load responses, and drives the single register-file write port.
module wb_unit
  import rv32i_defs_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255,
  parameter int TIMEOUT_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]       ex_result_i,
  input  logic                  ex_is_load_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [1:0]            ex_addr_lo_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic                  we_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  pending_o,
  output logic [REG_ADDR_W-1:0] pending_rd_o,
  output logic                  err_o
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOAD_TIMEOUT - 1);

  wb_state_e             state_q, state_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            alo_q, alo_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  pending_q, pending_d;
  logic [REG_ADDR_W-1:0] pendRd_q, pendRd_d;
  logic                  err_q, err_d;

  logic [XLEN-1:0]       alignData;
  logic                  alignErr;

  load_align u_align (
    .rdata_i   (mem_rdata_i),
    .funct3_i  (f3_q),
    .addr_lo_i (alo_q),
    .data_o    (alignData),
    .err_o     (alignErr)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      alo_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= 1'b0;
      pendRd_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      alo_q     <= alo_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      pendRd_q  <= pendRd_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    alo_d     = alo_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    pendRd_d  = pendRd_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        // A response with no load outstanding is a protocol error.
        if (mem_rvalid_i) err_d = 1'b1;
        if (ex_valid_i) begin
          if (ex_is_load_i) begin
            state_d   = WAIT_LOAD;
            cnt_d     = '0;
            f3_d      = ex_funct3_i;
            alo_d     = ex_addr_lo_i;
            pending_d = 1'b1;
            pendRd_d  = ex_rd_i;
          end else begin
            we_d    = (ex_rd_i != '0);
            waddr_d = ex_rd_i;
            wdata_d = ex_result_i;
          end
        end
      end
      WAIT_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          if (alignErr) begin
            err_d = 1'b1;
          end else begin
            we_d    = (pendRd_q != '0);
            waddr_d = pendRd_q;
            wdata_d = alignData;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          pending_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ex_ready_o   = (state_q == IDLE);
  assign we_o         = we_q;
  assign w_addr_o     = waddr_q;
  assign wdata_o      = wdata_q;
  assign pending_o    = pending_q;
  assign pending_rd_o = pendRd_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed plus randomized bench for wb_unit, checked against a cycle-level
// behavioural model of the writeback rules.
module tb_wb_unit;

  localparam int LOAD_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic        ex_is_load = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_addr_lo = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  w_addr;
  logic        we;
  logic [31:0] wdata;
  logic        pending;
  logic [4:0]  pending_rd;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        mLoad, mWe, mErr;
  logic [4:0]  mRd, mAddr;
  logic [2:0]  mF3;
  logic [1:0]  mAlo;
  logic [31:0] mData;
  int          mWait;

  always #5 clk = ~clk;

  wb_unit #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .TIMEOUT_W(8)) dut (
    .clk_i        (clk),
    .reset_n      (reset_n),
    .ex_valid_i   (ex_valid),
    .ex_ready_o   (ex_ready),
    .ex_rd_i      (ex_rd),
    .ex_result_i  (ex_result),
    .ex_is_load_i (ex_is_load),
    .ex_funct3_i  (ex_funct3),
    .ex_addr_lo_i (ex_addr_lo),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .w_addr_o     (w_addr),
    .we_o         (we),
    .wdata_o      (wdata),
    .pending_o    (pending),
    .pending_rd_o (pending_rd),
    .err_o        (err)
  );

  // Returns 1 when the load is legal; d gets the value the register should receive.
  function automatic logic fmtLoad(input logic [2:0] f3, input logic [1:0] alo,
                                   input logic [31:0] w, output logic [31:0] d);
    logic [31:0] b, h;
    b = (w >> (8 * int'(alo))) & 32'h0000_00FF;
    h = (w >> (alo >= 2'd2 ? 16 : 0)) & 32'h0000_FFFF;
    d = '0;
    case (f3)
      3'd0: begin d = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b; return 1'b1; end
      3'd4: begin d = b; return 1'b1; end
      3'd1: begin d = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; return (alo % 2) == 0; end
      3'd5: begin d = h; return (alo % 2) == 0; end
      3'd2: begin d = w; return alo == 2'd0; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".we"},      {31'b0, we},       {31'b0, mWe});
    chk({tag, ".ready"},   {31'b0, ex_ready}, {31'b0, ~mLoad});
    chk({tag, ".pending"}, {31'b0, pending},  {31'b0, mLoad});
    chk({tag, ".err"},     {31'b0, err},      {31'b0, mErr});
    if (mLoad) chk({tag, ".prd"}, {27'b0, pending_rd}, {27'b0, mRd});
    if (mWe) begin
      chk({tag, ".waddr"}, {27'b0, w_addr}, {27'b0, mAddr});
      chk({tag, ".wdata"}, wdata, mData);
    end
  endtask

  // Drives one cycle of inputs, advances the model and the DUT, then checks.
  task automatic applyStimulus(input string tag, input logic v, input logic [4:0] rd,
                               input logic [31:0] res, input logic ld, input logic [2:0] f3,
                               input logic [1:0] alo, input logic rv, input logic [31:0] rdata);
    logic        nWe;
    logic        ok;
    logic [31:0] d;
    ex_valid = v; ex_rd = rd; ex_result = res; ex_is_load = ld;
    ex_funct3 = f3; ex_addr_lo = alo; mem_rvalid = rv; mem_rdata = rdata;
    nWe = 1'b0;
    if (!mLoad) begin
      if (rv) mErr = 1'b1;
      if (v && ld) begin
        mLoad = 1'b1; mRd = rd; mF3 = f3; mAlo = alo; mWait = 0;
      end else if (v) begin
        nWe = (rd != 0);
        if (nWe) begin mAddr = rd; mData = res; end
      end
    end else begin
      mWait++;
      if (rv) begin
        mLoad = 1'b0;
        ok = fmtLoad(mF3, mAlo, rdata, d);
        if (!ok) mErr = 1'b1;
        else if (mRd != 0) begin nWe = 1'b1; mAddr = mRd; mData = d; end
      end else if (mWait == LOAD_TIMEOUT) begin
        mLoad = 1'b0;
        mErr  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    mWe = nWe;
    checkOutput(tag);
  endtask

  task automatic idleCyc(input string tag, input logic rv, input logic [31:0] rdata);
    applyStimulus(tag, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, rv, rdata);
  endtask

  task automatic doReset(input int n, input logic rvDuring);
    reset_n = 1'b0; ex_valid = 1'b0; mem_rvalid = rvDuring;
    repeat (n) @(posedge clk);
    #1;
    mLoad = 1'b0; mWe = 1'b0; mErr = 1'b0; mRd = '0; mAddr = '0; mData = '0; mWait = 0;
    chk("rst.waddr", {27'b0, w_addr}, 32'h0);
    chk("rst.wdata", wdata, 32'h0);
    chk("rst.prd", {27'b0, pending_rd}, 32'h0);
    checkOutput("rst");
    reset_n = 1'b1; mem_rvalid = 1'b0;
  endtask

  initial begin
    doReset(2, 1'b0);

    applyStimulus("alu1", 1, 5'd1, 32'hDEADBEEF, 0, 3'd0, 2'd0, 0, 0);
    chk("alu1.const", wdata, 32'hDEADBEEF);
    idleCyc("alu1.after", 0, 0);

    applyStimulus("b2b2", 1, 5'd2, 32'hCAFEBABE, 0, 3'd0, 2'd0, 0, 0);
    applyStimulus("b2b3", 1, 5'd3, 32'h12345678, 0, 3'd0, 2'd0, 0, 0);
    applyStimulus("b2b0", 1, 5'd0, 32'hFFFFFFFF, 0, 3'd0, 2'd0, 0, 0);

    applyStimulus("lb.acc", 1, 5'd5, 32'h0, 1, 3'd0, 2'd3, 0, 0);
    repeat (3) idleCyc("lb.wait", 0, 0);
    idleCyc("lb.resp", 1, 32'h80FF7F01);
    chk("lb.const", wdata, 32'hFFFFFF80);

    applyStimulus("lbu.acc", 1, 5'd5, 32'h0, 1, 3'd4, 2'd3, 0, 0);
    repeat (3) idleCyc("lbu.wait", 0, 0);
    idleCyc("lbu.resp", 1, 32'h80FF7F01);
    chk("lbu.const", wdata, 32'h00000080);

    applyStimulus("lh.acc", 1, 5'd6, 32'h0, 1, 3'd1, 2'd2, 0, 0);
    idleCyc("lh.resp", 1, 32'h80011234);
    chk("lh.const", wdata, 32'hFFFF8001);

    applyStimulus("lhu.acc", 1, 5'd7, 32'h0, 1, 3'd5, 2'd2, 0, 0);
    idleCyc("lhu.resp", 1, 32'h80011234);
    chk("lhu.const", wdata, 32'h00008001);

    applyStimulus("lhmis.acc", 1, 5'd8, 32'h0, 1, 3'd1, 2'd1, 0, 0);
    idleCyc("lhmis.resp", 1, 32'h80011234);
    chk("lhmis.err", {31'b0, err}, 32'h1);

    doReset(1, 1'b0);
    applyStimulus("to.acc", 1, 5'd9, 32'h0, 1, 3'd2, 2'd0, 0, 0);
    repeat (LOAD_TIMEOUT + 4) idleCyc("to.wait", 0, 0);
    chk("to.err", {31'b0, err}, 32'h1);
    chk("to.ready", {31'b0, ex_ready}, 32'h1);

    doReset(1, 1'b0);
    applyStimulus("rml.acc", 1, 5'd10, 32'h0, 1, 3'd2, 2'd0, 0, 0);
    repeat (2) idleCyc("rml.wait", 0, 0);
    doReset(2, 1'b1);
    chk("rml.err", {31'b0, err}, 32'h0);
    idleCyc("rml.after", 0, 0);
    idleCyc("idle.rvalid", 1, 32'h55AA55AA);

    doReset(1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (!mLoad)
        applyStimulus("rnd.idle", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), 1'b0, 32'h0);
      else
        applyStimulus("rnd.wait", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
